load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access size encoding,
// FSM states and the default memory-ack timeout.
package lsu_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeIll  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam int unsigned TimeoutCyclesDefault = 16;

    // Illegal size counts as misaligned so it takes the same error path.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        unique case (size)
            SizeByte: bad = 1'b0;
            SizeHalf: bad = addr_lo[0];
            SizeWord: bad = |addr_lo;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte enables, load byte/half
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        zero_ext,
    input  logic        store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_rep,
    output logic [3:0]  be,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  be_raw;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        wdata_rep = wdata;
        be_raw    = 4'b0000;
        rdata_ext = rdata;
        unique case (size)
            SizeByte: begin
                wdata_rep = {4{wdata[7:0]}};
                be_raw    = 4'b0001 << addr_lo;
                rdata_ext = zero_ext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SizeHalf: begin
                wdata_rep = {2{wdata[15:0]}};
                be_raw    = 4'b0011 << {addr_lo[1], 1'b0};
                rdata_ext = zero_ext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SizeWord: begin
                be_raw = 4'b1111;
            end
            default: begin
                be_raw = 4'b0000;
            end
        endcase
    end

    // Loads never drive byte enables.
    assign be = store ? be_raw : 4'b0000;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: registers one access, issues a held memory request,
// and returns a one-cycle response with alignment, illegal-size and timeout errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            store_q, store_d;
    size_e           size_q, size_d;
    logic            uns_q, uns_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     load_data;

    lsu_align u_align (
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .zero_ext  (uns_q),
        .store     (store_q),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wdata_rep (mem_wdata),
        .be        (mem_be),
        .rdata_ext (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            store_q     <= 1'b0;
            size_q      <= SizeByte;
            uns_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            store_q     <= store_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        store_d     = store_q;
        size_d      = size_q;
        uns_d       = uns_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_req     = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    store_d = req_store;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    if (is_misaligned(size_e'(req_size), req_addr[1:0])) begin
                        state_d     = StResp;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = StReq;
                        cnt_d   = '0;
                    end
                end
            end
            StReq: begin
                mem_req = 1'b1;
                // Ack is checked first so an ack in the last timeout cycle still succeeds.
                if (mem_ack) begin
                    state_d     = StResp;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = store_q ? 32'b0 : load_data;
                end else if (cnt_q == CntLast) begin
                    state_d     = StResp;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_we    = store_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
